microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Parametrised microcode sequencer that generates the CPU control word. It replaces the externally supplied control_word input of the current CPU top.
- Holds the instruction register and the microstep counter, and drives a synchronous microcode ROM addressed by {flags, opcode, step}.
- Supports free-run, single-step (edge-triggered), halt, and step-overflow fault detection.
- Sits between the clock/reset logic and the control-word splitter.

Parameters:
- CW_WIDTH, 32, control word width
- OPCODE_WIDTH, 8, instruction register width
- STEP_WIDTH, 4, microstep counter width; max step = 2^STEP_WIDTH-1
- FLAG_WIDTH, 4, ALU flag input width
- IR_LOAD_BIT, 31, control word bit that loads IR at end of step
- STEP_RST_BIT, 30, control word bit that ends the instruction (step <- 0)
- HALT_BIT, 29, control word bit that halts the sequencer

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- run  in  1  free-run enable, level
- step  in  1  single-step request; rising edge honoured only in WAIT
- flags  in  FLAG_WIDTH  ALU flags (already registered upstream)
- ir_in  in  OPCODE_WIDTH  opcode from main bus
- ucode_addr  out  FLAG_WIDTH+OPCODE_WIDTH+STEP_WIDTH  registered ROM address {flags, ir, step}
- ucode_data  in  CW_WIDTH  ROM data, valid one cycle after ucode_addr
- control_word  out  CW_WIDTH  active control word; 0 (NOP) outside EXEC
- cw_valid  out  1  high during EXEC
- step_cnt  out  STEP_WIDTH  current microstep
- ir_q  out  OPCODE_WIDTH  instruction register
- halted  out  1  sequencer stopped by HALT_BIT
- fault  out  1  sticky; step counter overflowed without STEP_RST

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rstn.
- Reset values (rstn low, asynchronous): state=WAIT, step_cnt=0, ir_q=0, ucode_addr=0, control_word=0, cw_valid=0, halted=0, fault=0, step edge register=0.
- States: WAIT, LOOKUP, EXEC, HALT.
- WAIT:
  - Goes to LOOKUP if run=1, or on a step rising edge (step=1 and registered step=0).
  - On that transition, ucode_addr <= {flags, ir_q, step_cnt}.
  - A held step advances exactly one microstep.
- LOOKUP: one cycle; the ROM samples ucode_addr; next state is EXEC.
- EXEC: one cycle; control_word=ucode_data (combinational pass-through) and cw_valid=1. At the end of EXEC, in priority order:
  - HALT_BIT set: go to HALT, halted<=1; step_cnt and ir_q unchanged; IR_LOAD_BIT is ignored.
  - Otherwise, IR_LOAD_BIT set: ir_q<=ir_in.
  - STEP_RST_BIT set: step_cnt<=0.
  - Else if step_cnt==max: step_cnt<=0 and fault<=1 (sticky until reset).
  - Else: step_cnt<=step_cnt+1.
  - Next state is LOOKUP if run=1 (with ucode_addr reloaded from the updated ir/step and the current flags), else WAIT.
- Throughput: one microstep per 2 clocks in free-run.
- Latency: step edge in WAIT to cw_valid is 2 cycles.
- HALT: control_word=0, cw_valid=0. Exit only via rstn; run and step are ignored.
- run dropped during LOOKUP/EXEC: the current step completes, then WAIT. It is never aborted mid-step.
- step edge while run=1 or outside WAIT: ignored, not queued.
- Flags are sampled only when ucode_addr is loaded; a flag change during EXEC affects the next step.
- IR load together with STEP_RST: both take effect; the next lookup uses the new opcode at step 0.
- Reset mid-EXEC: control_word goes to 0 immediately (asynchronous).

Test Plan:
1. Reset then run=1, ROM at {0,0x00,0} returns 0x8000_0000 (IR_LOAD), ir_in=0x3C → cw_valid on cycle 3; next ucode_addr={flags,0x3C,1}; ir_q=0x3C.
2. ROM step 2 returns 0x4000_0001 → control_word=0x4000_0001 for exactly one cycle; step_cnt returns to 0; following address step field=0.
3. run=0, step held high for 10 cycles → exactly one EXEC pulse; step_cnt 0→1. Release and re-pulse → second EXEC; step_cnt=2.
4. ROM returns 0x2000_0000 at step 1 → halted=1, control_word=0 thereafter with run=1 and step toggling; rstn pulse → state WAIT, halted=0, step_cnt=0.
5. ROM never sets STEP_RST for 16 steps, STEP_WIDTH=4 → after the step-15 EXEC: step_cnt=0, fault=1, execution continues; fault stays 1 until rstn.
6. flags=0x5 at WAIT→LOOKUP, changed to 0xA during EXEC, run=0 at EXEC → ucode_addr high nibble=0x5; WAIT entered; no further cw_valid.

Source files
------------

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_sequencer
//  Description : Microcode sequencer producing the CPU control word. Holds the
//                instruction register and microstep counter and addresses a
//                synchronous microcode ROM with {flags, opcode, step}. Supports
//                free-run, edge-triggered single-step, halt and a sticky fault
//                flag for microstep counter overflow.
//  Ports       :
//    clk          in   system clock, rising edge
//    rstn         in   asynchronous active-low reset
//    run          in   free-run enable (level)
//    step         in   single-step request, rising edge honoured in WAIT only
//    flags        in   ALU flags, sampled when the ROM address is loaded
//    ir_in        in   opcode from the main bus
//    ucode_addr   out  registered ROM address {flags, ir, step}
//    ucode_data   in   ROM data, valid one cycle after ucode_addr
//    control_word out  active control word, 0 (NOP) outside EXEC
//    cw_valid     out  high during EXEC
//    step_cnt     out  current microstep
//    ir_q         out  instruction register
//    halted       out  sequencer stopped by the halt bit
//    fault        out  sticky microstep overflow indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module microcode_sequencer #(
   parameter int CW_WIDTH     = 32,
   parameter int OPCODE_WIDTH = 8,
   parameter int STEP_WIDTH   = 4,
   parameter int FLAG_WIDTH   = 4,
   parameter int IR_LOAD_BIT  = 31,
   parameter int STEP_RST_BIT = 30,
   parameter int HALT_BIT     = 29
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic                                      run,
   input  logic                                      step,
   input  logic [FLAG_WIDTH-1:0]                     flags,
   input  logic [OPCODE_WIDTH-1:0]                   ir_in,
   output logic [FLAG_WIDTH+OPCODE_WIDTH+STEP_WIDTH-1:0] ucode_addr,
   input  logic [CW_WIDTH-1:0]                       ucode_data,
   output logic [CW_WIDTH-1:0]                       control_word,
   output logic                                      cw_valid,
   output logic [STEP_WIDTH-1:0]                     step_cnt,
   output logic [OPCODE_WIDTH-1:0]                   ir_q,
   output logic                                      halted,
   output logic                                      fault
);

   localparam int                    c_ADDR_W   = FLAG_WIDTH + OPCODE_WIDTH + STEP_WIDTH;
   localparam logic [STEP_WIDTH-1:0] c_STEP_MAX = '1;
   localparam logic [STEP_WIDTH-1:0] c_STEP_ONE = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [STEP_WIDTH-1:0]   r_step;
   logic [STEP_WIDTH-1:0]   w_step_nxt;
   logic [OPCODE_WIDTH-1:0] r_ir;
   logic [OPCODE_WIDTH-1:0] w_ir_nxt;
   logic [c_ADDR_W-1:0]     r_addr;
   logic [c_ADDR_W-1:0]     w_addr_nxt;
   logic                    r_halted;
   logic                    w_halted_nxt;
   logic                    r_fault;
   logic                    w_fault_nxt;
   logic                    r_step_q;
   logic                    w_step_edge;

   // A held step request produces a single edge, so it advances one microstep.
   assign w_step_edge = step & ~r_step_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= ST_WAIT;
         r_step   <= '0;
         r_ir     <= '0;
         r_addr   <= '0;
         r_halted <= 1'b0;
         r_fault  <= 1'b0;
         r_step_q <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_step   <= w_step_nxt;
         r_ir     <= w_ir_nxt;
         r_addr   <= w_addr_nxt;
         r_halted <= w_halted_nxt;
         r_fault  <= w_fault_nxt;
         r_step_q <= step;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_step_nxt   = r_step;
      w_ir_nxt     = r_ir;
      w_addr_nxt   = r_addr;
      w_halted_nxt = r_halted;
      w_fault_nxt  = r_fault;
      case (r_state)
         ST_WAIT: begin
            if (run || w_step_edge) begin
               w_state_nxt = ST_LOOKUP;
               w_addr_nxt  = {flags, r_ir, r_step};
            end
         end
         ST_LOOKUP: begin
            // ROM samples r_addr on this edge; its data is valid in EXEC.
            w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (ucode_data[HALT_BIT]) begin
               // Halt wins over every other control bit of this word.
               w_state_nxt  = ST_HALT;
               w_halted_nxt = 1'b1;
            end else begin
               if (ucode_data[IR_LOAD_BIT]) begin
                  w_ir_nxt = ir_in;
               end
               if (ucode_data[STEP_RST_BIT]) begin
                  w_step_nxt = '0;
               end else if (r_step == c_STEP_MAX) begin
                  w_step_nxt  = '0;
                  w_fault_nxt = 1'b1;
               end else begin
                  w_step_nxt = r_step + c_STEP_ONE;
               end
               if (run) begin
                  // Next lookup uses the updated opcode/step and live flags.
                  w_state_nxt = ST_LOOKUP;
                  w_addr_nxt  = {flags, w_ir_nxt, w_step_nxt};
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_WAIT;
         end
      endcase
   end

   // Decoded from the state register so an asynchronous reset forces NOP at once.
   assign cw_valid     = (r_state == ST_EXEC);
   assign control_word = cw_valid ? ucode_data : '0;
   assign ucode_addr   = r_addr;
   assign step_cnt     = r_step;
   assign ir_q         = r_ir;
   assign halted       = r_halted;
   assign fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_microcode_sequencer
//  Description : Self-checking bench for microcode_sequencer with a behavioural
//                synchronous microcode ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_microcode_sequencer;

   logic        clk;
   logic        rstn;
   logic        run;
   logic        step;
   logic [3:0]  flags;
   logic [7:0]  ir_in;
   logic [15:0] ucode_addr;
   logic [31:0] ucode_data;
   logic [31:0] control_word;
   logic        cw_valid;
   logic [3:0]  step_cnt;
   logic [7:0]  ir_q;
   logic        halted;
   logic        fault;

   int checks;
   int errors;

   logic [31:0] rom [0:65535];

   microcode_sequencer dut (
      .clk          (clk),
      .rstn         (rstn),
      .run          (run),
      .step         (step),
      .flags        (flags),
      .ir_in        (ir_in),
      .ucode_addr   (ucode_addr),
      .ucode_data   (ucode_data),
      .control_word (control_word),
      .cw_valid     (cw_valid),
      .step_cnt     (step_cnt),
      .ir_q         (ir_q),
      .halted       (halted),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data appears one cycle after the address is sampled.
   always @(posedge clk) ucode_data <= rom[ucode_addr];

   typedef struct {
      logic        run;
      logic [7:0]  ir_in;
      logic [3:0]  flags;
      logic        exp_valid;
      logic [31:0] exp_cw;
      logic [3:0]  exp_step;
      logic [7:0]  exp_ir;
      logic [15:0] exp_addr;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 65536; i++) rom[i] = 32'h0;
   endtask

   task automatic apply_reset();
      run   = 1'b0;
      step  = 1'b0;
      flags = 4'h0;
      ir_in = 8'h00;
      rstn  = 1'b0;
      tick();
      tick();
      chk("reset_state",
          {31'd0, cw_valid, control_word, step_cnt, ir_q, ucode_addr, halted, fault},
          64'd0);
      rstn = 1'b1;
   endtask

   initial begin
      int cnt;
      int cnt2;
      bit seen;
      bit bad;

      checks     = 0;
      errors     = 0;
      ucode_data = 32'h0;
      clear_rom();

      // ---------------- free-run table: IR load, step reset ----------------
      apply_reset();
      rom[16'h0000] = 32'h8000_0000;
      rom[16'h03C1] = 32'h0000_0011;
      rom[16'h03C2] = 32'h4000_0001;
      rom[16'h03C0] = 32'h0000_0002;
      //           run ir     fl    vld cw             stp   ir     addr
      vecs[0] = '{1'b1, 8'h3C, 4'h0, 1'b0, 32'h0000_0000, 4'd0, 8'h00, 16'h0000};
      vecs[1] = '{1'b1, 8'h3C, 4'h0, 1'b1, 32'h8000_0000, 4'd0, 8'h00, 16'h0000};
      vecs[2] = '{1'b1, 8'h3C, 4'h0, 1'b0, 32'h0000_0000, 4'd1, 8'h3C, 16'h03C1};
      vecs[3] = '{1'b1, 8'h3C, 4'h0, 1'b1, 32'h0000_0011, 4'd1, 8'h3C, 16'h03C1};
      vecs[4] = '{1'b1, 8'h3C, 4'h0, 1'b0, 32'h0000_0000, 4'd2, 8'h3C, 16'h03C2};
      vecs[5] = '{1'b1, 8'h3C, 4'h0, 1'b1, 32'h4000_0001, 4'd2, 8'h3C, 16'h03C2};
      vecs[6] = '{1'b1, 8'h3C, 4'h0, 1'b0, 32'h0000_0000, 4'd0, 8'h3C, 16'h03C0};
      vecs[7] = '{1'b1, 8'h3C, 4'h0, 1'b1, 32'h0000_0002, 4'd0, 8'h3C, 16'h03C0};
      vecs[8] = '{1'b0, 8'h3C, 4'h0, 1'b0, 32'h0000_0000, 4'd1, 8'h3C, 16'h03C0};
      vecs[9] = '{1'b0, 8'h3C, 4'h0, 1'b0, 32'h0000_0000, 4'd1, 8'h3C, 16'h03C0};
      for (int i = 0; i < 10; i++) begin
         run   = vecs[i].run;
         ir_in = vecs[i].ir_in;
         flags = vecs[i].flags;
         tick();
         chk($sformatf("vec%0d", i),
             {1'b0, cw_valid, control_word, step_cnt, ir_q, ucode_addr, halted, fault},
             {1'b0, vecs[i].exp_valid, vecs[i].exp_cw, vecs[i].exp_step, vecs[i].exp_ir,
              vecs[i].exp_addr, 1'b0, 1'b0});
      end

      // ---------------- single step: held and re-pulsed ----------------
      clear_rom();
      apply_reset();
      rom[16'h0000] = 32'h0000_0005;
      rom[16'h0001] = 32'h0000_0006;
      step = 1'b1;
      cnt  = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) chk("step_lat_lookup", {63'd0, cw_valid}, 64'd0);
         if (i == 1) chk("step_lat_exec", {32'd0, cw_valid, control_word[30:0]}, {32'd0, 1'b1, 31'h5});
         if (cw_valid) cnt++;
      end
      chk("held_step_pulses", cnt, 1);
      chk("held_step_cnt", step_cnt, 4'd1);
      step = 1'b0;
      tick();
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      cnt2 = 0;
      for (int i = 0; i < 6; i++) begin
         if (cw_valid) cnt2++;
         tick();
      end
      chk("repulse_pulses", cnt2, 1);
      chk("repulse_step_cnt", step_cnt, 4'd2);

      // ---------------- halt ----------------
      clear_rom();
      apply_reset();
      rom[16'h0001] = 32'hA000_0000;   // halt together with IR load
      ir_in = 8'h77;
      run   = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (halted) seen = 1'b1;
      end
      chk("halt_reached", {63'd0, seen}, 64'd1);
      chk("halt_ir_unchanged", ir_q, 8'h00);
      chk("halt_step_unchanged", step_cnt, 4'd1);
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step = ~step;
         tick();
         if (cw_valid || control_word != 32'h0 || !halted) bad = 1'b1;
      end
      chk("halt_sticky_nop", {63'd0, bad}, 64'd0);
      rstn = 1'b0;
      #1;
      chk("halt_async_reset", {58'd0, halted, step_cnt, cw_valid}, 64'd0);
      step = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      tick();
      chk("after_halt_runs", {63'd0, cw_valid}, 64'd1);

      // ---------------- step overflow fault ----------------
      clear_rom();
      apply_reset();
      for (int s = 0; s < 16; s++) rom[s] = 32'h0000_00F0;
      run  = 1'b1;
      cnt  = 0;
      seen = 1'b0;
      bad  = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (fault) seen = 1'b1;
         else if (cw_valid) cnt++;
      end
      chk("fault_set", {63'd0, seen}, 64'd1);
      chk("fault_after_16_exec", cnt, 16);
      chk("fault_step_wrap", step_cnt, 4'd0);
      cnt2 = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cw_valid) cnt2++;
         if (!fault) bad = 1'b1;
      end
      chk("fault_sticky", {63'd0, bad}, 64'd0);
      chk("fault_exec_continues", cnt2, 5);
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         if (cw_valid) seen = 1'b1;
         else tick();
      end
      chk("exec_before_reset", {32'd0, control_word}, {32'd0, 32'h0000_00F0});
      rstn = 1'b0;
      #1;
      chk("reset_mid_exec", {31'd0, cw_valid, control_word}, 64'd0);
      chk("reset_clears_fault", {63'd0, fault}, 64'd0);
      run = 1'b0;
      tick();
      rstn = 1'b1;

      // ---------------- flag sampling and run drop ----------------
      clear_rom();
      apply_reset();
      rom[16'h5000] = 32'h0000_0003;
      flags = 4'h5;
      step  = 1'b1;
      tick();
      chk("flag_addr_load", ucode_addr, 16'h5000);
      flags = 4'hA;
      step  = 1'b0;
      tick();
      chk("flag_exec", {31'd0, cw_valid, control_word}, {31'd0, 1'b1, 32'h0000_0003});
      tick();
      chk("flag_addr_hold", ucode_addr[15:12], 4'h5);
      chk("flag_step_cnt", step_cnt, 4'd1);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (cw_valid) cnt++;
      end
      chk("wait_no_exec", cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
